ifetch_unit: RTL and testbench

- Instruction fetch stage of the RV32I core; sits directly upstream of the main decoder, which consumes instr[6:0] as its opcode.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {instr, pc, pcplus4} to decode with a valid/ready handshake.
- Redirects on taken branch/jump from execute and discards any in-flight stale fetches.

---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifetch_fifo.sv | 65 ++++++
 rtl/ifetch_fifo_chk.sv | 14 +
 rtl/ifetch_unit.sv | 117 +++++++++++
 tb/tb_ifetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage and its decoder.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from registered storage.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  fetch_entry_t               i_wr_data,
    output fetch_entry_t               o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_full    = (r_count == DEPTH_C);
    assign w_do_pop  = i_pop & ~o_empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // pointer and occupancy update; flush empties the FIFO like reset does
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // entry storage
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_reset && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
    end

    ifetch_fifo_chk u_chk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_push),
        .i_pop   (w_do_pop),
        .i_flush (i_flush),
        .i_full  (o_full)
    );

endmodule

// File: rtl/ifetch_fifo_chk.sv
// Property checker for the fetch FIFO: a push into a full FIFO without a pop is illegal.
module ifetch_fifo_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_push,
    input logic i_pop,
    input logic i_flush,
    input logic i_full
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_push && i_full && !i_pop && !i_flush));

endmodule

// File: rtl/ifetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, response FIFO and redirect handling.
// Optional misaligned-target trap is enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic [XLEN-1:0]   instr_pcplus4,
    output logic              fetch_misaligned
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wr_entry;
    logic            w_credit_ok;
    logic            w_halt;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_live;
    logic [XLEN-1:0] w_rsp_pc;
    logic [XLEN-1:0] w_target;
    logic            w_unused;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_misaligned;

    assign w_target = redirect_pc;
    assign w_halt   = r_misaligned;

    // sticky trap on a redirect to a non-word-aligned target
    always_ff @(posedge clk) begin
        if (reset)                              r_misaligned <= 1'b0;
        else if (redirect && |redirect_pc[1:0]) r_misaligned <= 1'b1;
    end

    assign fetch_misaligned = r_misaligned;
`else
    assign w_target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_halt           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    assign w_credit_ok    = ({1'b0, r_outst} + {1'b0, w_fifo_count}) < DEPTH_C;
    assign imem_req_valid = ~reset & ~redirect & ~w_halt & w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // live (non-stale) fetches were issued back-to-back ending just below r_pc
    assign w_live     = r_outst - r_discard;
    assign w_rsp_pc   = r_pc - XLEN'({w_live, 2'b00});
    assign w_push     = imem_rsp_valid & ~redirect & (r_discard == {CW{1'b0}});
    assign w_wr_entry = '{instr: imem_rsp_data, pc: w_rsp_pc};

    assign instr_valid   = ~reset & ~w_fifo_empty;
    assign w_pop         = instr_valid & instr_ready;
    assign instr         = instr_valid ? w_head.instr : NOP_INSTR;
    assign instr_pc      = w_head.pc;
    assign instr_pcplus4 = pc_plus4(w_head.pc);

    assign w_unused = &{1'b0, redirect_pc[1:0], w_fifo_full};

    // PC and credit counters; redirect overrides normal issue/response bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_outst   <= {CW{1'b0}};
            r_discard <= {CW{1'b0}};
        end else if (redirect) begin
            r_pc      <= w_target;
            r_outst   <= r_outst - CW'(imem_rsp_valid);
            r_discard <= r_outst - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) r_pc <= r_pc + 32'd4;
            r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (r_discard != {CW{1'b0}})) r_discard <= r_discard - 1'b1;
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (redirect),
        .i_wr_data (w_wr_entry),
        .o_rd_data (w_head),
        .o_count   (w_fifo_count),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: scenario tasks plus a randomized run against a stream model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid, instr_ready = 1'b1;
    logic [31:0] instr, instr_pc, instr_pcplus4;
    logic        fetch_misaligned;

    logic        w_req_valid, w_rsp_valid = 1'b0;
    logic [31:0] w_req_addr, w_rsp_data = 32'd0;
    logic        w_instr_valid, w_misaligned;
    logic [31:0] w_instr, w_instr_pc, w_instr_pcplus4;
    logic        w_req_ready = 1'b1, w_instr_ready = 1'b1, w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'd0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mem_lat = 1;

    typedef struct { logic [31:0] addr; int cnt; } pend_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; } dlv_t;
    pend_t       pend_q[$];
    logic [31:0] req_log[$];
    dlv_t        dlv_q[$];
    logic [31:0] w_req_log[$];
    dlv_t        w_dlv_q[$];

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4), .fetch_misaligned(fetch_misaligned)
    );

    ifetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
        .instr_pc(w_instr_pc), .instr_pcplus4(w_instr_pcplus4), .fetch_misaligned(w_misaligned)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // instruction memory with mem_lat cycles of latency, plus request/delivery logs
    always @(posedge clk) begin
        if (reset) begin
            pend_q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'd0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{imem_req_addr, mem_lat - 1});
                req_log.push_back(imem_req_addr);
            end
            if (pend_q.size() > 0 && pend_q[0].cnt == 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= memfn(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            for (int i = 0; i < pend_q.size(); i++)
                if (pend_q[i].cnt > 0) pend_q[i].cnt = pend_q[i].cnt - 1;
            if (instr_valid && instr_ready)
                dlv_q.push_back('{instr, instr_pc, instr_pcplus4});
        end
    end

    // single-cycle memory for the wrap-around instance
    always @(posedge clk) begin
        if (reset) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= 32'd0;
        end else begin
            w_rsp_valid <= w_req_valid && w_req_ready;
            w_rsp_data  <= memfn(w_req_addr);
            if (w_req_valid && w_req_ready) w_req_log.push_back(w_req_addr);
            if (w_instr_valid && w_instr_ready)
                w_dlv_q.push_back('{w_instr, w_instr_pc, w_instr_pcplus4});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        req_log.delete(); dlv_q.delete(); w_req_log.delete(); w_dlv_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid got %b want 0", instr_valid); else pass_cnt++;
        total_cnt++; if (fetch_misaligned !== 1'b0) $display("FAIL rst_misaligned got %b want 0", fetch_misaligned); else pass_cnt++;
        repeat (2) @(negedge clk);
        req_log.delete(); dlv_q.delete();
        instr_ready = 1'b1;
        reset = 1'b0;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("FAIL rst_first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); else pass_cnt++;
        n = 0;
        while (instr_valid !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
        total_cnt++; if (n != 2) $display("FAIL rst_first_valid_latency got %0d edges want 2", n); else pass_cnt++;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8)
            $display("FAIL rst_req_seq got %h %h %h want 0 4 8", req_log[0], req_log[1], req_log[2]);
        else pass_cnt++;
        total_cnt++;
        if (dlv_q.size() < 3 || dlv_q[0].pc !== 32'h0 || dlv_q[1].pc !== 32'h4 || dlv_q[2].pc !== 32'h8)
            $display("FAIL rst_dlv_seq got %h %h %h want 0 4 8", dlv_q[0].pc, dlv_q[1].pc, dlv_q[2].pc);
        else pass_cnt++;
        total_cnt++;
        if (dlv_q.size() < 1 || dlv_q[0].instr !== memfn(32'h0) || dlv_q[0].pc4 !== 32'h4)
            $display("FAIL rst_dlv_data got i=%h p4=%h want i=%h p4=4", dlv_q[0].instr, dlv_q[0].pc4, memfn(32'h0));
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [31:0] h_instr, h_pc;
        bit have_head, stable_ok;
        int bad;
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b0;
        have_head = 1'b0; stable_ok = 1'b1;
        repeat (10) begin
            @(negedge clk); #1;
            if (instr_valid === 1'b1) begin
                if (!have_head) begin h_instr = instr; h_pc = instr_pc; have_head = 1'b1; end
                else if (instr !== h_instr || instr_pc !== h_pc) stable_ok = 1'b0;
            end else if (have_head) stable_ok = 1'b0;
        end
        total_cnt++; if (req_log.size() != 2) $display("FAIL stall_req_count got %0d want 2", req_log.size()); else pass_cnt++;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid got %b want 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (!have_head || !stable_ok || h_pc !== 32'h0) $display("FAIL stall_head_stable got have=%0d stable=%0d pc=%h want 1 1 0", have_head, stable_ok, h_pc); else pass_cnt++;
        @(negedge clk);
        instr_ready = 1'b1;
        repeat (20) @(negedge clk);
        bad = -1;
        for (int i = 0; i < dlv_q.size(); i++)
            if (bad < 0 && (dlv_q[i].pc !== 32'(4 * i) || dlv_q[i].instr !== memfn(32'(4 * i)))) bad = i;
        total_cnt++;
        if (dlv_q.size() < 10 || bad >= 0)
            $display("FAIL stall_release_seq got size=%0d first_bad=%0d want size>=10 first_bad=-1", dlv_q.size(), bad);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        int k;
        mem_lat = 2;
        do_reset();
        k = 0;
        while (req_log.size() < 2 && k < 20) begin @(negedge clk); k++; end
        total_cnt++; if (req_log.size() != 2 || dlv_q.size() != 0) $display("FAIL redir_setup got req=%0d dlv=%0d want 2 0", req_log.size(), dlv_q.size()); else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL redir_req_gated got %b want 0", imem_req_valid); else pass_cnt++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) $display("FAIL redir_next_req got v=%b a=%h want v=1 a=100", imem_req_valid, imem_req_addr); else pass_cnt++;
        repeat (20) @(negedge clk);
        total_cnt++;
        if (dlv_q.size() < 2 || dlv_q[0].pc !== 32'h100 || dlv_q[1].pc !== 32'h104 || dlv_q[0].instr !== memfn(32'h100))
            $display("FAIL redir_dlv got %h %h want 100 104", dlv_q[0].pc, dlv_q[1].pc);
        else pass_cnt++;
    endtask

    task automatic test_redirect_rsp_pop();
        bit found;
        int nb, bad;
        mem_lat = 1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #1;
            if (imem_rsp_valid === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) found = 1'b1;
        end
        total_cnt++; if (!found) $display("FAIL rrp_find got none want rsp+pop cycle"); else pass_cnt++;
        if (found) begin
            nb = dlv_q.size();
            redirect = 1'b1; redirect_pc = 32'h200;
            @(negedge clk);
            redirect = 1'b0;
            #1;
            total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rrp_valid_after got %b want 0", instr_valid); else pass_cnt++;
            repeat (20) @(negedge clk);
            bad = -1;
            for (int i = 0; i <= nb; i++)
                if (bad < 0 && dlv_q[i].pc !== 32'(4 * i)) bad = i;
            for (int i = 0; i < 3; i++)
                if (bad < 0 && (dlv_q[nb + 1 + i].pc !== 32'h200 + 32'(4 * i) ||
                                dlv_q[nb + 1 + i].instr !== memfn(32'h200 + 32'(4 * i)))) bad = nb + 1 + i;
            total_cnt++;
            if (dlv_q.size() < nb + 4 || bad >= 0)
                $display("FAIL rrp_stream got size=%0d first_bad=%0d want size>=%0d first_bad=-1", dlv_q.size(), bad, nb + 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (10) @(negedge clk);
        total_cnt++;
        if (w_req_log.size() < 2 || w_req_log[0] !== 32'hFFFF_FFFC || w_req_log[1] !== 32'h0)
            $display("FAIL wrap_req got %h %h want fffffffc 0", w_req_log[0], w_req_log[1]);
        else pass_cnt++;
        total_cnt++;
        if (w_dlv_q.size() < 2 || w_dlv_q[0].pc !== 32'hFFFF_FFFC || w_dlv_q[0].pc4 !== 32'h0 || w_dlv_q[1].pc !== 32'h0)
            $display("FAIL wrap_dlv got pc=%h pc4=%h next=%h want fffffffc 0 0", w_dlv_q[0].pc, w_dlv_q[0].pc4, w_dlv_q[1].pc);
        else pass_cnt++;
    endtask

    task automatic test_align();
        int bad;
        mem_lat = 1;
        do_reset();
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        #1;
`ifdef IFETCH_ALIGN_CHECK_EN
        total_cnt++; if (fetch_misaligned !== 1'b1) $display("FAIL align_flag got %b want 1", fetch_misaligned); else pass_cnt++;
        bad = 0;
        repeat (10) begin @(negedge clk); #1; if (imem_req_valid !== 1'b0 || fetch_misaligned !== 1'b1) bad++; end
        total_cnt++; if (bad != 0) $display("FAIL align_halt got %0d bad cycles want 0", bad); else pass_cnt++;
        do_reset();
        #1;
        total_cnt++; if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1) $display("FAIL align_clear got m=%b v=%b want 0 1", fetch_misaligned, imem_req_valid); else pass_cnt++;
`else
        bad = 0;
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) $display("FAIL align_forced got v=%b a=%h want v=1 a=100", imem_req_valid, imem_req_addr); else pass_cnt++;
        repeat (5) begin @(negedge clk); #1; if (fetch_misaligned !== 1'b0) bad++; end
        total_cnt++; if (bad != 0) $display("FAIL align_tied got %0d bad cycles want 0", bad); else pass_cnt++;
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_req, tgt, h_instr, h_pc;
        bit prev_hold;
        int pops;
        mem_lat = int'($urandom_range(1, 3));
        do_reset();
        exp_pc = 32'h0; exp_req = 32'h0; prev_hold = 1'b0; pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect       = ($urandom_range(0, 29) == 0);
            tgt            = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            redirect_pc    = tgt;
            #1;
            if (prev_hold) begin
                total_cnt++;
                if (instr_valid !== 1'b1 || instr !== h_instr || instr_pc !== h_pc)
                    $display("FAIL rnd_hold cyc=%0d got v=%b pc=%h want v=1 pc=%h", cyc, instr_valid, instr_pc, h_pc);
                else pass_cnt++;
            end
            if (redirect) begin
                total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rnd_redir_gate cyc=%0d got %b want 0", cyc, imem_req_valid); else pass_cnt++;
            end
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                total_cnt++;
                if (imem_req_addr !== exp_req) $display("FAIL rnd_req_addr cyc=%0d got %h want %h", cyc, imem_req_addr, exp_req); else pass_cnt++;
                exp_req = exp_req + 32'd4;
            end
            if (instr_valid === 1'b1 && instr_ready) begin
                total_cnt++;
                if (instr_pc !== exp_pc || instr !== memfn(exp_pc) || instr_pcplus4 !== exp_pc + 32'd4)
                    $display("FAIL rnd_dlv cyc=%0d got pc=%h i=%h p4=%h want pc=%h i=%h", cyc, instr_pc, instr, instr_pcplus4, exp_pc, memfn(exp_pc));
                else pass_cnt++;
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redirect) begin exp_pc = tgt; exp_req = tgt; end
            prev_hold = (instr_valid === 1'b1) && !instr_ready && !redirect;
            h_instr = instr; h_pc = instr_pc;
        end
        @(negedge clk);
        redirect = 1'b0;
        total_cnt++; if (pops < 100) $display("FAIL rnd_progress got %0d pops want >=100", pops); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_rsp_pop();
        test_wrap();
        test_align();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
